rgb_led_sequencer: RTL
======================

# rgb_led_sequencer

Controller that owns the three active-low RGB LED pins (RGB0/RGB1/RGB2) and sequences them from a small command interface. It generates a prescaled PWM time base, applies per-channel duty cycles, and steps through OFF / SOLID / BLINK / CYCLE patterns. Upstream logic issues pattern commands over a valid/ready handshake. The sequencer applies each command only on PWM period boundaries, so no partial period ever reaches the pins.

## Interface
- PWM_BITS, 8, PWM counter and per-channel duty width
- PRESCALE, 47, PWM tick every PRESCALE+1 clocks
- STEP_TICKS, 1000, PWM periods per pattern step (≥1)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge clk
- cmd_mode  input  2  0 OFF, 1 SOLID, 2 BLINK, 3 CYCLE
- cmd_duty  input  3*PWM_BITS  duties; [PWM_BITS-1:0]=RGB0, next=RGB1, top=RGB2
- busy  output  1  state != IDLE
- step_pulse  output  1  one-cycle pulse at each pattern step boundary
- RGB0, RGB1, RGB2  output  1 each  LED drive, registered, active-low (0 = lit)

## Operation
- Reset values: RGB0..2=1, cmd_ready=1, busy=0, step_pulse=0, all counters 0, state IDLE, phase=1, index=0. Reset asserted mid-operation aborts everything immediately (async).
- Prescaler pre_cnt 0..PRESCALE; pwm_tick when pre_cnt==PRESCALE.
- pwm_cnt (PWM_BITS) increments on pwm_tick, wraps 2^PWM_BITS-1→0; period_end = pwm_tick && pwm_cnt==all-ones.
- step_cnt 0..STEP_TICKS-1 increments on period_end; step_pulse = period_end && step_cnt==STEP_TICKS-1; wraps to 0.
- Channel i lit when duty_eff[i] > pwm_cnt (unsigned). Duty 0 = never lit; duty max = lit 2^N-1 of 2^N ticks.
- Modes:
  - OFF: all pins 1; all counters held at 0.
  - SOLID: each channel driven by its duty.
  - BLINK: phase toggles on step_pulse; phase=1 → SOLID, phase=0 → all off; starts phase=1.
  - CYCLE: index 0→1→2→0 on step_pulse; only channel[index] driven; starts index=0.
- FSM:
  - IDLE: cmd_ready=1. On accept with mode≠OFF, load mode/duty into active regs, clear all counters, phase=1, index=0 → RUN. Accept with OFF stays IDLE.
  - RUN: cmd_ready=1. On accept, latch into shadow regs → PEND.
  - PEND: cmd_ready=0. On period_end, copy shadow→active, clear step_cnt, phase=1, index=0. pre_cnt/pwm_cnt wrap naturally. Go to RUN, or to IDLE if shadow mode is OFF; pins go 1 from the next cycle.
- If period_end and an accept occur in the same RUN cycle, the command goes to shadow and applies at the following period_end.

## Timing
- Accept at edge k in IDLE: busy=1 and counters=0 after edge k. Pins reflect compare with pwm_cnt=0 after edge k+1.
- Pin latency: one clock after pwm_cnt/active-reg change (registered compare).
- step_pulse is asserted in the same cycle as the qualifying period_end, and is high for exactly one clock.
- Worst-case cmd_ready low time: one PWM period, (PRESCALE+1)·2^PWM_BITS clocks.

## Configuration
- RGB_LED_SEQ_GAMMA_EN defined: duty_eff = (duty·duty) >> PWM_BITS, using a 2·PWM_BITS product and its upper PWM_BITS bits. Computed from active regs. Example at 8 bits: 128→64, 255→254, 16→1.
- Not defined: duty_eff = duty.

## Test plan
- Reset: hold rst=0 mid-BLINK → RGB0..2=1, cmd_ready=1, busy=0 immediately; after release, IDLE with no pin activity.
- PWM_BITS=4, PRESCALE=0, SOLID with duties R=4, G=0, B=15 → RGB0 low 4 of every 16 clocks, RGB1 always 1, RGB2 low 15 of 16. busy=1.
- PWM_BITS=4, PRESCALE=0, STEP_TICKS=2, BLINK with all duties 8 → 32 clocks of 8/16 duty, then 32 clocks all 1, repeating. step_pulse every 32 clocks.
- Same parameters, CYCLE with duties 8 → lit channel rotates RGB0→RGB1→RGB2→RGB0 every 32 clocks; the other two pins stay 1.
- In RUN, issue a SOLID duty change at pwm_cnt=5 → cmd_ready=0 until period_end. The old duty completes the period; the new duty applies from pwm_cnt=0. A second cmd_valid is held off.
- Gamma, PWM_BITS=4, SOLID with R=8 → RGB0 low 4/16 with RGB_LED_SEQ_GAMMA_EN defined, 8/16 without.

Source files
------------

// File: rtl/rgb_led_sequencer_if.sv
// -----------------------------------------------------------------------------
// rgb_led_sequencer_if
//
// Purpose:
//   Command channel between upstream pattern logic and rgb_led_sequencer.
//   A command transfers on a rising clk edge when cmd_valid && cmd_ready.
//
// Parameters:
//   PWM_BITS   width of one channel duty value
//
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master sequencer can take a command
//   cmd_mode   master -> slave  0 OFF, 1 SOLID, 2 BLINK, 3 CYCLE
//   cmd_duty   master -> slave  {RGB2, RGB1, RGB0} duties, PWM_BITS each
//
// Modports:
//   master  upstream command source
//   slave   the sequencer
// -----------------------------------------------------------------------------
interface rgb_led_sequencer_if #(
    parameter int PWM_BITS = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_mode;
    logic [3*PWM_BITS-1:0]     cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_led_sequencer
//
// Purpose:
//   Owns the three active-low RGB LED pins. A prescaler produces a PWM tick,
//   a PWM_BITS counter compares against per-channel duties, and a pattern
//   step counter advances BLINK / CYCLE patterns. Commands arrive over a
//   valid/ready channel; while running, a new command is parked in shadow
//   registers and only applied on a PWM period boundary so the pins never
//   show a truncated period.
//
// Parameters:
//   PWM_BITS    PWM counter and per-channel duty width
//   PRESCALE    PWM tick every PRESCALE+1 clocks
//   STEP_TICKS  PWM periods per pattern step (>= 1)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   cmd         command channel (rgb_led_sequencer_if, slave modport)
//   busy        high whenever the sequencer is not idle
//   step_pulse  one-cycle pulse on each pattern step boundary
//   RGB0..RGB2  registered LED drives, active-low (0 = lit)
//
// Optional feature:
//   RGB_LED_SEQ_GAMMA_EN  when defined, each duty is squared and the upper
//                         PWM_BITS bits are used as the effective duty,
//                         giving a rough perceptual gamma curve.
// -----------------------------------------------------------------------------
module rgb_led_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 47,
    parameter int STEP_TICKS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    rgb_led_sequencer_if.slave    cmd,
    output logic                  busy,
    output logic                  step_pulse,
    output logic                  RGB0,
    output logic                  RGB1,
    output logic                  RGB2
);

    // A zero-width counter is not legal, so degenerate settings keep one bit.
    localparam int PRE_W  = (PRESCALE > 0)   ? $clog2(PRESCALE + 1) : 1;
    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS)   : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CYCLE = 2'd3
    } mode_t;

    state_t                  state;
    mode_t                   act_mode;
    mode_t                   shd_mode;
    mode_t                   cmd_mode_in;
    logic [3*PWM_BITS-1:0]   act_duty;
    logic [3*PWM_BITS-1:0]   shd_duty;
    logic [PRE_W-1:0]        pre_cnt;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [STEP_W-1:0]       step_cnt;
    logic                    phase;
    logic [1:0]              chan_idx;
    logic                    ready_q;

    logic                    running;
    logic                    pwm_tick;
    logic                    period_end;
    logic                    step_last;
    logic                    accept;
    logic [2:0][PWM_BITS-1:0] duty_eff;
    logic [2:0]              lit;
    logic [2:0]              chan_en;
    logic [2:0]              drive;

    assign cmd.cmd_ready = ready_q;
    assign cmd_mode_in   = mode_t'(cmd.cmd_mode);
    assign accept        = cmd.cmd_valid && ready_q;

    // The time base only runs while a pattern is active; in IDLE every
    // counter sits at zero, so the tick must be gated or PRESCALE=0 would
    // fire it continuously.
    assign running    = (state != IDLE);
    assign pwm_tick   = running && (pre_cnt == PRE_MAX);
    assign period_end = pwm_tick && (&pwm_cnt);
    assign step_last  = (step_cnt == STEP_MAX);
    assign step_pulse = period_end && step_last;

    // Effective duty per channel, always derived from the active registers
    // so a pending command cannot disturb the period in progress.
    for (genvar ch = 0; ch < 3; ch++) begin : g_duty
        logic [PWM_BITS-1:0] duty_raw;
        assign duty_raw = act_duty[ch*PWM_BITS +: PWM_BITS];
`ifdef RGB_LED_SEQ_GAMMA_EN
        logic [2*PWM_BITS-1:0] duty_sq;
        assign duty_sq      = {{PWM_BITS{1'b0}}, duty_raw} * {{PWM_BITS{1'b0}}, duty_raw};
        assign duty_eff[ch] = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
        assign duty_eff[ch] = duty_raw;
`endif
        assign lit[ch] = (duty_eff[ch] > pwm_cnt);
    end

    // Which channels the current pattern is allowed to light.
    always_comb begin
        chan_en = 3'b000;
        case (act_mode)
            MODE_SOLID: chan_en = 3'b111;
            MODE_BLINK: chan_en = {3{phase}};
            MODE_CYCLE: chan_en = 3'b001 << chan_idx;
            default:    chan_en = 3'b000;
        endcase
    end

    assign drive = lit & chan_en;

    // Control FSM, time base and pin registers together. Pins are registered
    // from the current compare, so they trail pwm_cnt / active regs by one
    // clock. In PEND the shadow command is swapped in on period_end; the
    // prescaler and PWM counter wrap to zero on that same edge by themselves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            act_mode <= MODE_OFF;
            shd_mode <= MODE_OFF;
            act_duty <= '0;
            shd_duty <= '0;
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            phase    <= 1'b1;
            chan_idx <= 2'd0;
            ready_q  <= 1'b1;
            busy     <= 1'b0;
            RGB0     <= 1'b1;
            RGB1     <= 1'b1;
            RGB2     <= 1'b1;
        end else begin
            if (state == IDLE) begin
                {RGB2, RGB1, RGB0} <= 3'b111;
            end else begin
                {RGB2, RGB1, RGB0} <= ~drive;
            end

            if (running) begin
                if (pwm_tick) begin
                    pre_cnt <= '0;
                    pwm_cnt <= pwm_cnt + 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
                if (period_end) begin
                    step_cnt <= step_last ? '0 : step_cnt + 1'b1;
                end
                if (step_pulse) begin
                    phase    <= ~phase;
                    chan_idx <= (chan_idx == 2'd2) ? 2'd0 : chan_idx + 2'd1;
                end
            end

            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept && (cmd_mode_in != MODE_OFF)) begin
                        act_mode <= cmd_mode_in;
                        act_duty <= cmd.cmd_duty;
                        pre_cnt  <= '0;
                        pwm_cnt  <= '0;
                        step_cnt <= '0;
                        phase    <= 1'b1;
                        chan_idx <= 2'd0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (accept) begin
                        shd_mode <= cmd_mode_in;
                        shd_duty <= cmd.cmd_duty;
                        ready_q  <= 1'b0;
                        state    <= PEND;
                    end
                end

                PEND: begin
                    if (period_end) begin
                        act_mode <= shd_mode;
                        act_duty <= shd_duty;
                        step_cnt <= '0;
                        phase    <= 1'b1;
                        chan_idx <= 2'd0;
                        ready_q  <= 1'b1;
                        if (shd_mode == MODE_OFF) begin
                            pre_cnt <= '0;
                            pwm_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state   <= RUN;
                        end
                    end
                end

                default: begin
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
